// File: rtl/vending_pkg.sv
// Shared state constants, coin denominations and the coin acceptance check.
package vending_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CREDIT = 2'd1;
  localparam state_t ST_VEND   = 2'd2;
  localparam state_t ST_CHANGE = 2'd3;

  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_20 = 20;

  // True for a denomination the acceptor is allowed to take.
  function automatic logic coin_ok(input logic [31:0] v);
    return (v == 32'(COIN_5)) || (v == 32'(COIN_10)) || (v == 32'(COIN_20));
  endfunction

endpackage

// File: rtl/vending_stock.sv
// Per-item stock counters with a registered empty flag per item.
module vending_stock #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned IW         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restock,
  input  logic                 dec,
  input  logic [IW-1:0]        dec_item,
  output logic [NUM_ITEMS-1:0] empty
);

  logic [STOCK_W-1:0]   cnt_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   cnt_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] empty_q;
  logic [NUM_ITEMS-1:0] empty_d;

  // Reload on restock, otherwise decrement the vended item (never below zero).
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (restock) begin
        cnt_d[i] = STOCK_W'(STOCK_INIT);
      end else if (dec && (dec_item == IW'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - STOCK_W'(1);
      end
      empty_d[i] = (cnt_d[i] == '0);
    end
  end

  // Counter and empty-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        cnt_q[i] <= STOCK_W'(STOCK_INIT);
      end
      empty_q <= {NUM_ITEMS{(STOCK_INIT == 0)}};
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      empty_q <= empty_d;
    end
  end

  assign empty = empty_q;

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: credit accumulation, selection, vend and change handshake.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd30, 8'd55, 8'd39, 8'd20},
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 8,
  localparam int unsigned IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_val,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_item,
  input  logic                cancel,
  input  logic                restock,
  output logic                coin_reject,
  output logic                dispense,
  output logic [IW-1:0]       dispense_item,
  output logic                sold_out,
  output logic                need_credit,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_amount,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IW-1:0]       item_q, item_d;
  logic                coin_reject_q, coin_reject_d;
  logic                dispense_q, dispense_d;
  logic [IW-1:0]       dispense_item_q, dispense_item_d;
  logic                sold_out_q, sold_out_d;
  logic                need_credit_q, need_credit_d;
  logic                chg_valid_q, chg_valid_d;
  logic [CREDIT_W-1:0] chg_amount_q, chg_amount_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0]  price_tbl [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] empty;
  logic [SUM_W-1:0]     coin_sum;
  logic                 coin_accept;
  logic                 sel_ok;
  logic                 stock_dec;
  logic                 stock_restock;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
    assign price_tbl[g] = PRICES[g*CREDIT_W +: CREDIT_W];
  end

  vending_stock #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT),
    .IW         (IW)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .restock  (stock_restock),
    .dec      (stock_dec),
    .dec_item (item_q),
    .empty    (empty)
  );

  // Next-state and registered-output logic; cancel > select > coin priority.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    item_d          = item_q;
    coin_reject_d   = 1'b0;
    dispense_d      = 1'b0;
    dispense_item_d = '0;
    sold_out_d      = 1'b0;
    need_credit_d   = 1'b0;
    chg_valid_d     = chg_valid_q;
    chg_amount_d    = chg_amount_q;
    stock_dec       = 1'b0;
    stock_restock   = 1'b0;

    sel_ok      = sel_valid && (32'(sel_item) < NUM_ITEMS);
    coin_sum    = SUM_W'(credit_q) + SUM_W'(coin_val);
    coin_accept = coin_ok(32'(coin_val)) && (coin_sum <= SUM_W'(MAX_CREDIT));

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (state_q == ST_CREDIT)) begin
          state_d       = ST_CHANGE;
          chg_valid_d   = 1'b1;
          chg_amount_d  = credit_q;
          coin_reject_d = coin_valid;
        end else if (sel_ok) begin
          coin_reject_d = coin_valid;
          if (empty[sel_item]) begin
            sold_out_d = 1'b1;
          end else if (credit_q < price_tbl[sel_item]) begin
            need_credit_d = 1'b1;
          end else begin
            state_d         = ST_VEND;
            item_d          = sel_item;
            dispense_d      = 1'b1;
            dispense_item_d = sel_item;
          end
        end else if (coin_valid) begin
          if (coin_accept) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        stock_restock = restock && (state_q == ST_IDLE);
      end
      ST_VEND: begin
        coin_reject_d = coin_valid;
        credit_d      = credit_q - price_tbl[item_q];
        stock_dec     = 1'b1;
        if (credit_d != '0) begin
          state_d      = ST_CHANGE;
          chg_valid_d  = 1'b1;
          chg_amount_d = credit_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_ready) begin
          credit_d     = '0;
          chg_valid_d  = 1'b0;
          chg_amount_d = '0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      item_q          <= '0;
      coin_reject_q   <= 1'b0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      sold_out_q      <= 1'b0;
      need_credit_q   <= 1'b0;
      chg_valid_q     <= 1'b0;
      chg_amount_q    <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      item_q          <= item_d;
      coin_reject_q   <= coin_reject_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      sold_out_q      <= sold_out_d;
      need_credit_q   <= need_credit_d;
      chg_valid_q     <= chg_valid_d;
      chg_amount_q    <= chg_amount_d;
      busy_q          <= busy_d;
    end
  end

  assign coin_reject   = coin_reject_q;
  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign sold_out      = sold_out_q;
  assign need_credit   = need_credit_q;
  assign chg_valid     = chg_valid_q;
  assign chg_amount    = chg_amount_q;
  assign credit        = credit_q;
  assign busy          = busy_q;

endmodule
